alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream result bundle and op are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the stage accepts a bundle this cycle.
REQ-006 The block SHALL have port op, input, 3 bits: result select.
REQ-007 The block SHALL have ports a_plus_b, a_minus_b, not_a, a_and_b, a_or_b, a_xor_b, each input, DATA_WIDTH bits: the ALU result bus.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream consumes the head entry.
REQ-010 The block SHALL have port out_result, output, DATA_WIDTH bits: the selected result.
REQ-011 The block SHALL have ports out_zero, out_neg, out_err, each output, 1 bit: flags for the head entry.
REQ-012 The block SHALL have port err_count, output, 8 bits: a saturating count of accepted illegal ops.

Function
REQ-013 The op decode SHALL be: 0 = a_plus_b, 1 = a_minus_b, 2 = not_a, 3 = a_and_b, 4 = a_or_b, 5 = a_xor_b, 6 and 7 = illegal.
REQ-014 On a legal op, the stored result SHALL equal the selected bus, zero SHALL be 1 iff the result is all zeros, neg SHALL equal result MSB, and err SHALL be 0.
REQ-015 On an illegal op, the stored result SHALL be 0, with zero = 0, neg = 0 and err = 1.
REQ-016 The storage SHALL be a 2-entry in-order FIFO with a registered occupancy count of 0, 1 or 2.
REQ-017 in_ready SHALL be 1 iff the count is less than 2, decoded from registered state only with no combinational path from out_ready.
REQ-018 A push SHALL occur iff in_valid and in_ready are both 1; a pop SHALL occur iff out_valid and out_ready are both 1.
REQ-019 out_valid SHALL be 1 iff the count is greater than 0; out_result and the flags SHALL always present the head entry.
REQ-020 Latency: a bundle pushed at edge N with the FIFO empty SHALL appear on the outputs after edge N.
REQ-021 Simultaneous push and pop at count 1 SHALL leave the count at 1, with the new entry becoming head after the edge.
REQ-022 At count 2, in_ready SHALL be 0, so a pop alone takes the count to 1.
REQ-023 At count 0, out_ready SHALL be ignored and no underflow SHALL occur.
REQ-024 While out_valid = 1 and out_ready = 0, the head outputs SHALL remain stable.
REQ-025 The FIFO SHALL preserve entry order: output order SHALL equal acceptance order, with no loss or duplication.
REQ-026 err_count SHALL increment by 1 on each push with an illegal op and SHALL saturate at 255.
REQ-027 The ALU buses SHALL be sampled only on a push cycle; their values in other cycles SHALL have no effect.

Reset
REQ-028 While rst_n = 0, the block SHALL hold count = 0, out_valid = 0, in_ready = 0, out_result = 0, out_zero = 0, out_neg = 0, out_err = 0 and err_count = 0, with assertion acting immediately and independent of clk.
REQ-029 In the first cycle after rst_n deasserts, in_ready SHALL be 1.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; no entry SHALL appear after release.

Verification
REQ-031 The bench SHALL drive a = 5, b = 6 (plus 0x000B, minus 0xFFFF, not 0xFFFA, and 0x0004, or 0x0007, xor 0x0003) and push ops 0..5 with out_ready = 1, requiring the results in that order with neg = 1 only for ops 1 and 2 and zero = 0 for all.
REQ-032 The bench SHALL push ops 3 then 5 with out_ready = 0, requiring in_ready = 0 after the second push, out_result held at 0x0004, then 0x0004 and 0x0003 in order once out_ready = 1.
REQ-033 The bench SHALL push op 6 and op 7, requiring out_result = 0, out_err = 1 on both and err_count = 2; after 300 illegal pushes, err_count SHALL equal 255.
REQ-034 The bench SHALL hold continuous in_valid = 1 and out_ready = 1 at count 1, requiring one output per cycle with the count steady at 1.
REQ-035 The bench SHALL assert rst_n = 0 asynchronously with count = 2, requiring out_valid = 0 immediately and no stale output after release.
REQ-036 The bench SHALL drive op 1 with a = b = 0x1234 (a_minus_b = 0), requiring out_result = 0x0000, out_zero = 1 and out_neg = 0.

Source files
------------

// File: rtl/alu_result_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_result_if : ALU result bus, op select and output handshake     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface alu_result_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            op;
   logic [DATA_WIDTH-1:0] a_plus_b;
   logic [DATA_WIDTH-1:0] a_minus_b;
   logic [DATA_WIDTH-1:0] not_a;
   logic [DATA_WIDTH-1:0] a_and_b;
   logic [DATA_WIDTH-1:0] a_or_b;
   logic [DATA_WIDTH-1:0] a_xor_b;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_result;
   logic                  out_zero;
   logic                  out_neg;
   logic                  out_err;
   logic [7:0]            err_count;

   modport master (
      output in_valid, op, a_plus_b, a_minus_b, not_a, a_and_b, a_or_b, a_xor_b, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_neg, out_err, err_count
   );

   modport slave (
      input  in_valid, op, a_plus_b, a_minus_b, not_a, a_and_b, a_or_b, a_xor_b, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_neg, out_err, err_count
   );
endinterface
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_result_stage : op-selected ALU result with flags, 2-entry FIFO |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_result_stage #(
   parameter int DATA_WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_result_if.slave   bus
);
   localparam logic [1:0] C_FULL = 2'd2;

   logic [DATA_WIDTH-1:0] r_res [2];
   logic [2:0]            r_flags [2];   // {zero, neg, err}
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;
   logic [7:0]            r_err_count;

   logic [DATA_WIDTH-1:0] w_sel;
   logic                  w_legal;
   logic [DATA_WIDTH-1:0] w_result;
   logic [2:0]            w_flags;
   logic                  w_in_ready;
   logic                  w_out_valid;
   logic                  w_push;
   logic                  w_pop;

   always_comb begin
      w_sel   = '0;
      w_legal = 1'b1;
      case (bus.op)
         3'd0:    w_sel = bus.a_plus_b;
         3'd1:    w_sel = bus.a_minus_b;
         3'd2:    w_sel = bus.not_a;
         3'd3:    w_sel = bus.a_and_b;
         3'd4:    w_sel = bus.a_or_b;
         3'd5:    w_sel = bus.a_xor_b;
         default: w_legal = 1'b0;
      endcase
   end

   assign w_result = w_legal ? w_sel : '0;
   assign w_flags  = {w_legal & (w_sel == '0), w_legal & w_sel[DATA_WIDTH-1], ~w_legal};

   // rst_n gating keeps in_ready low throughout reset and high on the first cycle after release
   assign w_in_ready  = rst_n & (r_count != C_FULL);
   assign w_out_valid = (r_count != 2'd0);
   assign w_push      = bus.in_valid & w_in_ready;
   assign w_pop       = w_out_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res[0]    <= '0;
         r_res[1]    <= '0;
         r_flags[0]  <= '0;
         r_flags[1]  <= '0;
         r_wr_ptr    <= 1'b0;
         r_rd_ptr    <= 1'b0;
         r_count     <= 2'd0;
         r_err_count <= 8'd0;
      end else begin
         if (w_push) begin
            r_res[r_wr_ptr]   <= w_result;
            r_flags[r_wr_ptr] <= w_flags;
            r_wr_ptr          <= ~r_wr_ptr;
            if (!w_legal && r_err_count != 8'hFF)
               r_err_count <= r_err_count + 8'd1;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_result = r_res[r_rd_ptr];
   assign bus.out_zero   = r_flags[r_rd_ptr][2];
   assign bus.out_neg    = r_flags[r_rd_ptr][1];
   assign bus.out_err    = r_flags[r_rd_ptr][0];
   assign bus.err_count  = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_result_stage : vector table, corner sequences, random run   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_alu_result_stage;
   localparam int W = 16;

   typedef struct {
      logic [W-1:0] res;
      logic         zero;
      logic         neg;
      logic         err;
   } ent_t;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         zero;
      logic         neg;
      logic         err;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   ent_t q[$];
   int   exp_errs;

   alu_result_if #(.DATA_WIDTH(W)) bus_if ();

   alu_result_stage #(.DATA_WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ent_t ref_entry(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      ent_t e;
      int   legal;
      legal = 1;
      e.res = '0;
      case (op)
         3'd0:    e.res = a + b;
         3'd1:    e.res = a - b;
         3'd2:    e.res = ~a;
         3'd3:    e.res = a & b;
         3'd4:    e.res = a | b;
         3'd5:    e.res = a ^ b;
         default: legal = 0;
      endcase
      e.err  = (legal == 0);
      e.zero = (legal != 0) && (e.res == 0);
      e.neg  = (legal != 0) && e.res[W-1];
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("out_valid", 32'(bus_if.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(bus_if.in_ready), 32'(q.size() < 2));
      chk("err_count", 32'(bus_if.err_count), 32'(exp_errs));
      if (q.size() != 0) begin
         chk("head_result", 32'(bus_if.out_result), 32'(q[0].res));
         chk("head_zero", 32'(bus_if.out_zero), 32'(q[0].zero));
         chk("head_neg", 32'(bus_if.out_neg), 32'(q[0].neg));
         chk("head_err", 32'(bus_if.out_err), 32'(q[0].err));
      end
   endtask

   // Drive one cycle from a negedge, update the scoreboard at the posedge, check at the next negedge.
   task automatic cycle(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic r);
      logic push;
      logic pop;
      bus_if.in_valid  = v;
      bus_if.op        = op;
      bus_if.a_plus_b  = a + b;
      bus_if.a_minus_b = a - b;
      bus_if.not_a     = ~a;
      bus_if.a_and_b   = a & b;
      bus_if.a_or_b    = a | b;
      bus_if.a_xor_b   = a ^ b;
      bus_if.out_ready = r;
      push = v && (q.size() < 2);
      pop  = r && (q.size() != 0);
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (push) begin
         q.push_back(ref_entry(op, a, b));
         if (op > 3'd5 && exp_errs < 255) exp_errs++;
      end
      @(negedge clk);
      check_model();
   endtask

   task automatic idle(input logic r);
      cycle(1'b0, 3'($urandom), W'($urandom), W'($urandom), r);
   endtask

   task automatic check_reset_outputs();
      chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
      chk("rst_out_result", 32'(bus_if.out_result), 32'd0);
      chk("rst_flags", {29'd0, bus_if.out_zero, bus_if.out_neg, bus_if.out_err}, 32'd0);
      chk("rst_err_count", 32'(bus_if.err_count), 32'd0);
   endtask

   vec_t tbl[7];

   initial begin
      total    = 0;
      bad      = 0;
      exp_errs = 0;
      rst_n    = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b0;
      bus_if.op        = 3'd0;
      bus_if.a_plus_b  = '0;
      bus_if.a_minus_b = '0;
      bus_if.not_a     = '0;
      bus_if.a_and_b   = '0;
      bus_if.a_or_b    = '0;
      bus_if.a_xor_b   = '0;

      tbl[0] = '{3'd0, 16'h0005, 16'h0006, 16'h000B, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{3'd1, 16'h0005, 16'h0006, 16'hFFFF, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{3'd2, 16'h0005, 16'h0006, 16'hFFFA, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{3'd3, 16'h0005, 16'h0006, 16'h0004, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{3'd4, 16'h0005, 16'h0006, 16'h0007, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{3'd5, 16'h0005, 16'h0006, 16'h0003, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst_n = 1'b1;
      #1;
      chk("in_ready_after_release", 32'(bus_if.in_ready), 32'd1);
      @(negedge clk);

      // Streamed pushes with out_ready=1: each entry is head right after its push edge.
      for (int i = 0; i < 7; i++) begin
         cycle(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b1);
         chk("tbl_valid", 32'(bus_if.out_valid), 32'd1);
         chk("tbl_result", 32'(bus_if.out_result), 32'(tbl[i].res));
         chk("tbl_zero", 32'(bus_if.out_zero), 32'(tbl[i].zero));
         chk("tbl_neg", 32'(bus_if.out_neg), 32'(tbl[i].neg));
         chk("tbl_err", 32'(bus_if.out_err), 32'(tbl[i].err));
      end
      idle(1'b1);
      chk("drained", 32'(bus_if.out_valid), 32'd0);

      // Backpressure: fill, hold, then drain in order.
      cycle(1'b1, 3'd3, 16'h0005, 16'h0006, 1'b0);
      cycle(1'b1, 3'd5, 16'h0005, 16'h0006, 1'b0);
      chk("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
      chk("bp_head", 32'(bus_if.out_result), 32'h0004);
      cycle(1'b1, 3'd0, 16'h7777, 16'h1111, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(1'b0);
         chk("bp_hold", 32'(bus_if.out_result), 32'h0004);
      end
      idle(1'b1);
      chk("bp_second", 32'(bus_if.out_result), 32'h0003);
      idle(1'b1);
      chk("bp_empty", 32'(bus_if.out_valid), 32'd0);

      // Illegal ops and err_count saturation.
      cycle(1'b1, 3'd6, 16'h0005, 16'h0006, 1'b1);
      chk("ill6_result", 32'(bus_if.out_result), 32'd0);
      chk("ill6_err", 32'(bus_if.out_err), 32'd1);
      cycle(1'b1, 3'd7, 16'h0005, 16'h0006, 1'b1);
      chk("ill7_result", 32'(bus_if.out_result), 32'd0);
      chk("ill7_err", 32'(bus_if.out_err), 32'd1);
      chk("err_count_2", 32'(bus_if.err_count), 32'd2);
      for (int i = 0; i < 300; i++)
         cycle(1'b1, 3'(6 + (i % 2)), W'($urandom), W'($urandom), 1'b1);
      chk("err_count_sat", 32'(bus_if.err_count), 32'd255);
      idle(1'b1);

      // Continuous flow at count 1.
      cycle(1'b1, 3'd0, 16'h0001, 16'h0002, 1'b0);
      for (int i = 0; i < 20; i++) begin
         logic [2:0]   op;
         logic [W-1:0] a;
         logic [W-1:0] b;
         ent_t         e;
         op = 3'($urandom_range(0, 5));
         a  = W'($urandom);
         b  = W'($urandom);
         e  = ref_entry(op, a, b);
         cycle(1'b1, op, a, b, 1'b1);
         chk("flow_valid", 32'(bus_if.out_valid), 32'd1);
         chk("flow_in_ready", 32'(bus_if.in_ready), 32'd1);
         chk("flow_head", 32'(bus_if.out_result), 32'(e.res));
      end
      idle(1'b1);

      // Asynchronous reset while full.
      cycle(1'b1, 3'd4, 16'h00F0, 16'h000F, 1'b0);
      cycle(1'b1, 3'd2, 16'h0F0F, 16'h0000, 1'b0);
      chk("full_before_rst", 32'(bus_if.in_ready), 32'd0);
      #2;
      bus_if.in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      q.delete();
      exp_errs = 0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready_after_rst2", 32'(bus_if.in_ready), 32'd1);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         chk("no_stale", 32'(bus_if.out_valid), 32'd0);
      end

      // Random traffic against the scoreboard.
      for (int i = 0; i < 600; i++)
         cycle(1'($urandom), 3'($urandom), W'($urandom), W'($urandom), 1'($urandom));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
